// File: rtl/mtl_trace_sequencer.sv
// Steps one finite trace through a bank of timed MTL monitor cells: sample stream in, per-step verdicts out.
// Optional abort input enabled by defining MTL_SEQ_ABORT_EN.
module mtl_trace_sequencer #(
  parameter int HORIZON   = 16,
  parameter int NUM_PROPS = 4,
  parameter int NUM_MON   = 4,
  parameter int IDX_W     = $clog2(HORIZON)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef MTL_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [NUM_PROPS-1:0] s_phi,
  input  logic                 s_last,
  output logic [NUM_PROPS-1:0] mon_phi,
  output logic [0:HORIZON-1]   mon_t,
  output logic                 mon_ce,
  output logic                 mon_clr,
  input  logic [NUM_MON-1:0]   mon_y,
  output logic                 v_valid,
  input  logic                 v_ready,
  output logic [NUM_MON-1:0]   v_y,
  output logic [IDX_W-1:0]     v_idx,
  output logic                 v_last,
  output logic                 busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CLR, ST_RUN, ST_FLUSH} state_t;

  // Leftmost element of the [0:N-1] vector is step 0.
  localparam logic [0:HORIZON-1] T_STEP0 = {1'b1, {(HORIZON-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic                   last_taken_q, last_taken_d;
  logic                   stg_valid_q, stg_valid_d;
  logic [IDX_W-1:0]       stg_idx_q, stg_idx_d;
  logic                   stg_last_q, stg_last_d;
  logic [NUM_PROPS-1:0]   mon_phi_q, mon_phi_d;
  logic [0:HORIZON-1]     mon_t_q, mon_t_d;
  logic                   v_valid_q, v_valid_d;
  logic [NUM_MON-1:0]     v_y_q, v_y_d;
  logic [IDX_W-1:0]       v_idx_q, v_idx_d;
  logic                   v_last_q, v_last_d;
  logic                   mon_clr_q, mon_clr_d;
  logic                   busy_q, busy_d;

  logic abort_w;
  logic kill;
  logic ce_w;
  logic ready_w;
  logic hs;

`ifdef MTL_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign kill    = abort_w & ((state_q == ST_CLR) | (state_q == ST_RUN));
  // The bank only steps when the verdict register can take its result.
  assign ce_w    = stg_valid_q & (~v_valid_q | v_ready) & ~kill;
  assign ready_w = (state_q == ST_RUN) & ~last_taken_q & (~stg_valid_q | ce_w) & ~kill;
  assign hs      = s_valid & ready_w;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_taken_d = last_taken_q;
    stg_valid_d  = stg_valid_q;
    stg_idx_d    = stg_idx_q;
    stg_last_d   = stg_last_q;
    mon_phi_d    = mon_phi_q;
    mon_t_d      = mon_t_q;
    v_valid_d    = v_valid_q;
    v_y_d        = v_y_q;
    v_idx_d      = v_idx_q;
    v_last_d     = v_last_q;

    if (ce_w) begin
      stg_valid_d = 1'b0;
      v_valid_d   = 1'b1;
      v_y_d       = mon_y;
      v_idx_d     = stg_idx_q;
      v_last_d    = stg_last_q;
    end else if (v_ready) begin
      v_valid_d = 1'b0;
    end

    if (hs) begin
      stg_valid_d      = 1'b1;
      stg_idx_d        = cnt_q;
      stg_last_d       = s_last | (cnt_q == IDX_W'(HORIZON-1));
      mon_phi_d        = s_phi;
      mon_t_d          = '0;
      mon_t_d[cnt_q]   = 1'b1;
      cnt_d            = cnt_q + IDX_W'(1);
      last_taken_d     = s_last | (cnt_q == IDX_W'(HORIZON-1));
    end

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLR;
      ST_CLR: begin
        cnt_d        = '0;
        last_taken_d = 1'b0;
        stg_valid_d  = 1'b0;
        v_valid_d    = 1'b0;
        state_d      = ST_RUN;
      end
      ST_RUN:   if (last_taken_q & ~stg_valid_q & ~v_valid_q) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d     = ST_FLUSH;
      stg_valid_d = 1'b0;
      v_valid_d   = 1'b0;
    end
  end

  assign mon_clr_d = (state_d == ST_CLR) | (state_d == ST_FLUSH);
  assign busy_d    = (state_d != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_taken_q <= 1'b0;
      stg_valid_q  <= 1'b0;
      stg_idx_q    <= '0;
      stg_last_q   <= 1'b0;
      mon_phi_q    <= '0;
      mon_t_q      <= T_STEP0;
      v_valid_q    <= 1'b0;
      v_y_q        <= '0;
      v_idx_q      <= '0;
      v_last_q     <= 1'b0;
      mon_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_taken_q <= last_taken_d;
      stg_valid_q  <= stg_valid_d;
      stg_idx_q    <= stg_idx_d;
      stg_last_q   <= stg_last_d;
      mon_phi_q    <= mon_phi_d;
      mon_t_q      <= mon_t_d;
      v_valid_q    <= v_valid_d;
      v_y_q        <= v_y_d;
      v_idx_q      <= v_idx_d;
      v_last_q     <= v_last_d;
      mon_clr_q    <= mon_clr_d;
      busy_q       <= busy_d;
    end
  end

  assign s_ready = ready_w;
  assign mon_ce  = ce_w;
  assign mon_phi = mon_phi_q;
  assign mon_t   = mon_t_q;
  assign mon_clr = mon_clr_q;
  assign v_valid = v_valid_q;
  assign v_y     = v_y_q;
  assign v_idx   = v_idx_q;
  assign v_last  = v_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mtl_trace_sequencer.sv
// Directed bench for mtl_trace_sequencer; a toy monitor bank returns y = phi ^ step index.
module tb_mtl_trace_sequencer;
  localparam int H  = 16;
  localparam int P  = 4;
  localparam int M  = 4;
  localparam int IW = 4;

  typedef logic [0:H-1] tvec_t;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_last, v_ready;
  logic [P-1:0]  s_phi;
  logic          s_ready, mon_ce, mon_clr, v_valid, v_last, busy;
  logic [P-1:0]  mon_phi;
  tvec_t         mon_t;
  logic [M-1:0]  mon_y, v_y;
  logic [IW-1:0] v_idx;
`ifdef MTL_SEQ_ABORT_EN
  logic          abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mtl_trace_sequencer #(.HORIZON(H), .NUM_PROPS(P), .NUM_MON(M), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef MTL_SEQ_ABORT_EN
    .abort(abort),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_phi(s_phi), .s_last(s_last),
    .mon_phi(mon_phi), .mon_t(mon_t), .mon_ce(mon_ce), .mon_clr(mon_clr), .mon_y(mon_y),
    .v_valid(v_valid), .v_ready(v_ready), .v_y(v_y), .v_idx(v_idx), .v_last(v_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [M-1:0] enc;
    enc = '0;
    for (int i = 0; i < H; i++) if (mon_t[i]) enc = M'(i);
    mon_y = mon_phi ^ enc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic tvec_t oh(input int k);
    tvec_t r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [P-1:0] phi_of(input int k, input int mode);
    return (mode == 0) ? P'(1) : P'(k * 3);
  endfunction

  task automatic start_trace();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("clr_pulse", mon_clr, 1);
    chk("clr_ready", s_ready, 0);
    chk("clr_busy", busy, 1);
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 12 && busy; i++) tick();
    #1;
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  // Back-to-back stream of n samples with v_ready=1, entered on the first RUN cycle.
  task automatic stream(input int n, input int start_cyc, input int mode, input int use_last);
    for (int c = 0; c <= n + 4; c++) begin
      s_valid = (c <= n);
      s_last  = (use_last != 0) && (c == n - 1);
      s_phi   = phi_of(c, mode);
      start   = (c == start_cyc);
      v_ready = 1'b1;
      #1;
      chk("s_ready", s_ready, c < n);
      chk("mon_ce", mon_ce, (c >= 1) && (c <= n));
      if (c >= 1 && c <= n) begin
        chk("mon_t", mon_t, oh(c - 1));
        chk("mon_phi", mon_phi, phi_of(c - 1, mode));
      end
      chk("v_valid", v_valid, (c >= 2) && (c <= n + 1));
      if (c >= 2 && c <= n + 1) begin
        $display("verdict idx=%0d y=%0h last=%0b", v_idx, v_y, v_last);
        chk("v_idx", v_idx, c - 2);
        chk("v_y", v_y, phi_of(c - 2, mode) ^ M'(c - 2));
        chk("v_last", v_last, (c - 2) == (n - 1));
      end
      chk("mon_clr", mon_clr, c == n + 3);
      chk("busy", busy, c <= n + 3);
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; v_ready = 1'b1; s_phi = '0;
`ifdef MTL_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    #1;
    chk("rst_mon_t", mon_t, oh(0));
    chk("rst_busy", busy, 0);
    chk("rst_v_valid", v_valid, 0);
    chk("rst_mon_clr", mon_clr, 0);
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    tick();

    // Three samples, last on the third.
    start_trace();
    stream(3, -1, 0, 1);

    // Verdict stall for five cycles.
    start_trace();
    v_ready = 1'b0; s_valid = 1'b1; s_phi = 4'h2; s_last = 1'b0;
    #1; chk("st0_ready", s_ready, 1); chk("st0_ce", mon_ce, 0); tick();
    #1; chk("st1_ready", s_ready, 1); chk("st1_ce", mon_ce, 1); tick();
    for (int c = 2; c <= 4; c++) begin
      #1;
      chk("stall_ce", mon_ce, 0);
      chk("stall_ready", s_ready, 0);
      chk("stall_v_idx", v_idx, 0);
      chk("stall_v_y", v_y, 4'h2);
      chk("stall_mon_t", mon_t, oh(1));
      tick();
    end
    v_ready = 1'b1;
    #1; chk("rel_ce", mon_ce, 1); chk("rel_ready", s_ready, 1); tick();
    s_last = 1'b1;
    #1; chk("rel_v_idx1", v_idx, 1); chk("rel_v_y1", v_y, 4'h3); chk("rel_mon_t2", mon_t, oh(2)); tick();
    s_valid = 1'b0; s_last = 1'b0;
    #1; chk("rel_v_idx2", v_idx, 2); chk("rel_v_y2", v_y, 4'h0); chk("rel_mon_t3", mon_t, oh(3));
    chk("rel_ready_done", s_ready, 0); tick();
    #1; chk("rel_v_idx3", v_idx, 3); chk("rel_v_last", v_last, 1); chk("rel_v_y3", v_y, 4'h1); tick();
    wait_idle();

    // Full horizon, no s_last; a 17th sample is refused.
    start_trace();
    stream(16, -1, 1, 0);

    // start during RUN is ignored.
    start_trace();
    stream(4, 2, 1, 1);

    // Reset with both stages full.
    start_trace();
    v_ready = 1'b0; s_valid = 1'b1; s_phi = 4'h5;
    tick(); tick();
    #1;
    chk("full_v_valid", v_valid, 1);
    chk("full_ce", mon_ce, 0);
    rst = 1'b1;
    #1;
    chk("mrst_v_valid", v_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_mon_t", mon_t, oh(0));
    chk("mrst_mon_phi", mon_phi, 0);
    chk("mrst_ce", mon_ce, 0);
    chk("mrst_ready", s_ready, 0);
    chk("mrst_v_idx", v_idx, 0);
    s_valid = 1'b0; v_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start_trace();
    stream(2, -1, 1, 1);

`ifdef MTL_SEQ_ABORT_EN
    // Abort together with the idx-2 handshake.
    start_trace();
    v_ready = 1'b1; s_valid = 1'b1; s_phi = 4'h1; s_last = 1'b0;
    tick(); tick();
    abort = 1'b1;
    #1; chk("ab_ready", s_ready, 0);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    #1;
    chk("ab_v_valid", v_valid, 0);
    chk("ab_ce", mon_ce, 0);
    chk("ab_clr", mon_clr, 1);
    chk("ab_busy", busy, 1);
    tick();
    #1;
    chk("ab_idle", busy, 0);
    chk("ab_clr_off", mon_clr, 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mtl_trace_sequencer.md
Name: mtl_trace_sequencer

Overview:
- Sequences one finite trace through a bank of timed MTL monitor cells.
- Each monitor cell takes a one-hot time vector `t`, a proposition bit `phi` and clock-enable/clear controls, and returns a combinational verdict `y`.
- Accepts trace samples over a valid/ready stream and drives the cells one step per accepted sample.
- Captures the per-step verdict vector with its step index, and clears the bank between traces.
- Sits between the trace DMA/stream source and the monitor bank.

Parameters:
- HORIZON, 16, trace length limit in steps; width of the one-hot time vector; must be ≥2.
- NUM_PROPS, 4, number of atomic propositions per sample.
- NUM_MON, 4, number of monitor cells whose `y` is collected.
- IDX_W, $clog2(HORIZON), width of the step index.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  pulse; begins a trace (honoured only in IDLE)
- s_valid  input  1  sample valid
- s_ready  output  1  sample ready
- s_phi  input  NUM_PROPS  proposition values of the sample
- s_last  input  1  final sample of the trace
- mon_phi  output  NUM_PROPS  registered propositions to the bank
- mon_t  output  HORIZON  one-hot current time; bit 0 = step 0 (MSB-first, matching the cells' [0:N-1] vectors)
- mon_ce  output  1  bank step enable, one cycle per step
- mon_clr  output  1  synchronous clear of the bank
- mon_y  input  NUM_MON  combinational verdicts, valid in the mon_ce cycle
- v_valid  output  1  verdict valid
- v_ready  input  1  verdict ready
- v_y  output  NUM_MON  captured verdicts
- v_idx  output  IDX_W  step index of the verdict
- v_last  output  1  verdict belongs to the final step
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except mon_t = one-hot bit 0. State = IDLE, step counter = 0.
- States:
  - IDLE: s_ready=0. start → CLR.
  - CLR: exactly 1 cycle, mon_clr=1. Step counter and stage valids cleared. → RUN.
  - RUN: accepts samples (rules below). Moves to FLUSH once the last step has been accepted and both pipeline stages are empty.
  - FLUSH: 1 cycle, mon_clr=1. → IDLE.
- Pipeline stage S1 (step register):
  - Holds mon_phi, mon_t, idx, last and stg_valid.
  - Loads on an s_valid & s_ready handshake.
  - mon_ce = stg_valid & (!v_valid | v_ready).
  - S1 drains on mon_ce; in that same cycle mon_y is captured into v_y/v_idx/v_last and v_valid is set.
- Stage S2 (verdict register): v_valid clears on v_ready unless reloaded in the same cycle.
- s_ready = RUN & !last_taken & (!stg_valid | mon_ce). Sustains 1 sample/clk when v_ready=1.
- Latency: handshake at cycle N → mon_ce at N+1 → v_valid at N+2.
- mon_ce is never asserted while S2 is stalled, so the monitor state only advances once per step.
- mon_phi and mon_t are held stable while S1 is stalled.
- Step counter increments on each handshake. mon_t = 1 << (HORIZON-1-idx) in MSB-first order, i.e. bit idx set.
- last_taken sets on a handshake with s_last=1, or on the handshake at idx = HORIZON-1 (forced end; that verdict has v_last=1).
- Further samples are not accepted until the next start.
- start outside IDLE is ignored.
- An s_valid with s_last=1 in a step other than the final step is legal.
- Reset mid-trace: everything returns to reset values immediately. A verdict in flight is lost. The bank must be cleared by the next CLR.

Optional Feature:
- Macro: MTL_SEQ_ABORT_EN.
- With the macro defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in CLR or RUN: next state FLUSH; S1 and S2 are discarded (v_valid=0 next cycle, no further mon_ce); s_ready=0 that cycle.
  - abort in IDLE or FLUSH: ignored.
  - abort wins over a simultaneous handshake; that sample is dropped.
- Without the macro: no `abort` port; a trace ends only via s_last, the horizon, or rst.

Test Plan:
1. Reset, then start; 3 samples s_phi=4'b0001 back-to-back with s_last on the 3rd, v_ready=1 → mon_clr pulses 1 cycle; mon_ce on 3 consecutive cycles with mon_t bits 0, 1, 2; verdicts at idx 0, 1, 2 each 2 cycles after their handshake; v_last=1 on idx 2; FLUSH mon_clr; busy falls.
2. v_ready=0 for 5 cycles while streaming → at most 2 samples accepted; mon_ce=0 throughout the stall; v_y/v_idx held; on release, resumes at 1 step/clk with no lost or duplicated idx.
3. 16 samples with HORIZON=16 and no s_last → handshake at idx 15 sets v_last=1; 17th s_valid sees s_ready=0 until the next start.
4. start pulsed during RUN → ignored; idx sequence is unaffected.
5. rst asserted while S1 and S2 are both full → all outputs reset on the same edge; new start gives mon_clr, then idx restarts at 0.
6. (MTL_SEQ_ABORT_EN) abort asserted together with a handshake at idx 2 → that sample is dropped; v_valid=0 next cycle; FLUSH mon_clr=1; IDLE the cycle after.
